// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: processes DIGIT bits of a WIDTH-bit operand pair per clock, with flags
// and a stored carry for chained ADC/SBB, behind valid/ready handshakes on both sides.
module digit_serial_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             negf,
  output logic             zf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_c_q, run_c_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             negf_q, negf_d, zf_q, zf_d;

  logic             is_arith;
  logic [DIGIT-1:0] da, db, dres;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] dres_ext;

  // Digit datapath: operands shift right, so the current digit is always the low slice.
  always_comb begin
    is_arith = ~op_q[2];
    da       = a_q[DIGIT-1:0];
    db       = (is_arith && op_q[0]) ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    sum      = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, run_c_q};
    case (op_q)
      3'b100:  dres = da & db;
      3'b101:  dres = da | db;
      3'b110:  dres = da ^ db;
      3'b111:  dres = '0;
      default: dres = sum[DIGIT-1:0];
    endcase
    dres_ext              = '0;
    dres_ext[DIGIT-1:0]   = dres;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_c_d   = run_c_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    negf_d    = negf_q;
    zf_d      = zf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          // ADC/SBB chain through the stored carry; SUB injects the +1 of two's complement.
          run_c_d = op[1] ? carry_q : op[0];
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = (acc_q >> DIGIT) | (dres_ext << (WIDTH - DIGIT));
        run_c_d = sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d    = cnt_q;
          state_d  = StDone;
          result_d = acc_d;
          negf_d   = acc_d[WIDTH-1];
          zf_d     = (acc_d == '0);
          carry_d  = is_arith & sum[DIGIT];
          // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
          ovf_d    = is_arith & (sum[DIGIT] ^ da[DIGIT-1] ^ db[DIGIT-1] ^ sum[DIGIT-1]);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_c_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      negf_q   <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_c_q  <= run_c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      negf_q   <= negf_d;
      zf_q     <= zf_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign negf   = negf_q;
  assign zf     = zf_q;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Scoreboard bench for digit_serial_alu: runs one directed suite on each of three
// configurations (8/2, 16/4, 4/4); a negedge monitor checks every consumed result.
module tb_digit_serial_alu;

  typedef struct {
    logic [15:0] res;
    logic        c, v, n, z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [1:0]  sel;
  int          n_cur;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  // Per-instance outputs
  logic [7:0]  r0;
  logic [15:0] r1;
  logic [3:0]  r2;
  logic [2:0]  iv, ir, ov, cy, vf, nf, zv;

  assign iv[0] = in_valid && (sel == 2'd0);
  assign iv[1] = in_valid && (sel == 2'd1);
  assign iv[2] = in_valid && (sel == 2'd2);

  digit_serial_alu #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(op), .a(a[7:0]),
    .b(b[7:0]), .out_valid(ov[0]), .out_ready(out_ready), .result(r0), .carry(cy[0]),
    .ovf(vf[0]), .negf(nf[0]), .zf(zv[0])
  );

  digit_serial_alu #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(op), .a(a),
    .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(r1), .carry(cy[1]),
    .ovf(vf[1]), .negf(nf[1]), .zf(zv[1])
  );

  digit_serial_alu #(.WIDTH(4), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .op(op), .a(a[3:0]),
    .b(b[3:0]), .out_valid(ov[2]), .out_ready(out_ready), .result(r2), .carry(cy[2]),
    .ovf(vf[2]), .negf(nf[2]), .zf(zv[2])
  );

  logic [15:0] s_result;
  logic        s_in_ready, s_out_valid, s_carry, s_ovf, s_negf, s_zf;

  always_comb begin
    s_result    = 16'h0;
    s_in_ready  = ir[sel];
    s_out_valid = ov[sel];
    s_carry     = cy[sel];
    s_ovf       = vf[sel];
    s_negf      = nf[sel];
    s_zf        = zv[sel];
    case (sel)
      2'd0:    s_result = {8'h0, r0};
      2'd1:    s_result = r1;
      default: s_result = {12'h0, r2};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cfg %0d): got %0h, expected %0h at %0t", name, sel, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, v, n, z);
    exp_t e;
    e.res = r; e.c = c; e.v = v; e.n = n; e.z = z;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake that the coming edge will complete.
  always @(negedge clk) begin
    if (!rst && s_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'b0, s_out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {16'h0, s_result}, {16'h0, e.res});
        check("carry", {31'b0, s_carry}, {31'b0, e.c});
        check("ovf", {31'b0, s_ovf}, {31'b0, e.v});
        check("negf", {31'b0, s_negf}, {31'b0, e.n});
        check("zf", {31'b0, s_zf}, {31'b0, e.z});
      end
    end
  end

  task automatic wait_out();
    int lat = 0;
    while (!s_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, n_cur);
  endtask

  // Accepts one op; returns #1 after the edge where out_valid rises.
  task automatic send(input logic [2:0] o, input logic [15:0] x, y, input exp_t e);
    check("in_ready_idle", {31'b0, s_in_ready}, 32'd1);
    exp_q.push_back(e);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = ~o; a = ~x; b = ~y;
    wait_out();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_result"}, {16'h0, s_result}, 32'd0);
    check({tag, "_flags"}, {28'b0, s_carry, s_ovf, s_negf, s_zf}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, s_in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, s_out_valid}, 32'd0);
  endtask

  task automatic run_suite(input logic [1:0] s, input int n, input logic [15:0] m);
    logic [15:0] msb;
    msb   = (m >> 1) + 16'h1;
    sel   = s;
    n_cur = n;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    check_cleared("reset");

    send(3'b000, m >> 1, 16'h1, mk(msb, 1'b0, 1'b1, 1'b1, 1'b0)); tick();
    send(3'b001, 16'h5, 16'h5, mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b1)); tick();
    send(3'b001, 16'h0, 16'h1, mk(m, 1'b0, 1'b0, 1'b1, 1'b0)); tick();
    send(3'b000, m, 16'h1, mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b1)); tick();
    send(3'b010, 16'h0, 16'h0, mk(16'h1, 1'b0, 1'b0, 1'b0, 1'b0)); tick();
    send(3'b011, 16'h0, 16'h0, mk(m, 1'b0, 1'b0, 1'b1, 1'b0)); tick();

    // Backpressure: result held while a new op waits at the input.
    out_ready = 1'b0;
    send(3'b110, 16'hAAAA & m, 16'h5555 & m, mk(m, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(16'h3, 1'b0, 1'b0, 1'b0, 1'b0));
    op = 3'b101; a = 16'h0; b = 16'h3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_result", {16'h0, s_result}, {16'h0, m});
      check("stall_flags", {28'b0, s_carry, s_ovf, s_negf, s_zf}, 32'b0010);
      check("stall_out_valid", {31'b0, s_out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, s_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("release_in_ready", {31'b0, s_in_ready}, 32'd1);
    check("release_out_valid", {31'b0, s_out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("next_accepted", {31'b0, s_in_ready}, 32'd0);
    wait_out(); tick();

    // Reset mid-RUN after priming the stored carry to 1.
    send(3'b000, m, 16'h1, mk(16'h0, 1'b1, 1'b0, 1'b0, 1'b1)); tick();
    op = 3'b000; a = m; b = 16'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (n > 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("midrun_reset");
    for (int i = 0; i < n + 2; i++) begin
      tick();
      check("no_out_valid_after_reset", {31'b0, s_out_valid}, 32'd0);
    end
    send(3'b010, 16'h4, 16'h1, mk(16'h5, 1'b0, 1'b0, 1'b0, 1'b0)); tick();

    send(3'b111, 16'h3C & m, 16'hC3 & m, mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b1)); tick();
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'b0; a = 16'h0; b = 16'h0;
    sel = 2'd0; n_cur = 4;
    tick(); tick();
    run_suite(2'd0, 4, 16'h00FF);
    run_suite(2'd1, 4, 16'hFFFF);
    run_suite(2'd2, 1, 16'h000F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
